// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: machine widths, PC step,
// fetch sequencer states and the buffered fetch entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_INCR = 32'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry response buffer of {pc, instr}. Flush beats push/pop, and a
// simultaneous push and pop is legal even when the buffer is full.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [ILEN-1:0] push_instr_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] head_pc_o,
    output logic [ILEN-1:0] head_instr_o,
    output logic [1:0]      count_o,
    output logic            empty_o,
    output logic            full_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 2'd1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            // NOTE: the storage is reset too because the head is visible on
            // out_instr/out_pc, which must read zero straight after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{pc: push_pc_i, instr: push_instr_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_pc_o    = mem_q[rd_ptr_q].pc;
    assign head_instr_o = mem_q[rd_ptr_q].instr;
    assign count_o      = count_q;
    assign empty_o      = (count_q == 2'd0);
    assign full_o       = (count_q == 2'd2);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks the single in-flight
// synchronous memory read, and buffers responses toward decode.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        misalign_err
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            misalign_q, misalign_d;

    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;

    // A redirect flushes the buffer, so the head is never consumed that cycle.
    assign pop = out_valid && out_ready && !redirect_valid;

    // Entries held or owed after this cycle; an issue needs a free slot for
    // the response that lands one cycle later.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    assign issue = (state_q == RUN) && !halt && !redirect_valid && (occupancy < DEPTH);

    // The credit rule keeps room for every response; the full check only
    // guards the buffer against a push it could not hold.
    assign push = inflight_q && !redirect_valid && (!fifo_full || pop);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        misalign_d    = misalign_q;

        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = RUN;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (issue) begin
                pc_d          = pc_q + PC_INCR;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (state_q == RUN && halt) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_pc_i    (inflight_pc_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    assign imem_addr    = pc_q;
    assign out_valid    = !fifo_empty;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a synchronous-read instruction memory
// model; expectations are hand-derived cycle by cycle.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [1024];

    fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory whose output register clears on reset.
    always @(posedge clk) begin
        if (reset) imem_rdata <= 32'h0;
        else       imem_rdata <= mem[imem_addr[11:2]];
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        case (pc[11:2])
            10'd0:   return 32'h0000_0013;
            10'd1:   return 32'h0010_0093;
            default: return 32'hA000_0000 | {20'h0, pc[11:0]};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, instr_of(pc));
    endtask

    task automatic idle(input string tag, input logic [31:0] addr);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd0);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = instr_of(32'(i) << 2);

        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        repeat (3) tick();

        // Reset state
        idle("rst", 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'd0);

        // Streaming: first valid two cycles after release, one beat per cycle
        reset = 1'b0;
        idle("c0", 32'h0);
        tick(); idle("c1", 32'h4);
        tick(); beat("s0", 32'h0); check("s0_addr", imem_addr, 32'h8);
        tick(); beat("s4", 32'h4);
        tick(); beat("s8", 32'h8);
        tick(); beat("sc", 32'hC);

        // Fill the buffer, then reset mid-stream
        out_ready = 1'b0;
        tick(); beat("fullA", 32'hC);
        tick(); beat("fullB", 32'hC); check("full_addr", imem_addr, 32'h14);
        reset = 1'b1;
        tick();
        idle("midrst", 32'h0);
        check("midrst_pc", out_pc, 32'h0);

        // Restart with backpressure from the first valid beat
        reset = 1'b0;
        idle("r_c0", 32'h0);
        tick(); idle("r_c1", 32'h4);
        tick(); beat("bp0", 32'h0); check("bp0_addr", imem_addr, 32'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            beat("bp_hold", 32'h0);
            check("bp_addr", imem_addr, 32'h8);
        end
        out_ready = 1'b1;
        tick(); beat("bp4", 32'h4);
        tick(); beat("bp8", 32'h8);
        tick(); beat("bpc", 32'hC);
        check("pre_redir_addr", imem_addr, 32'h14);

        // Redirect to 0x40 with one entry buffered and one read in flight
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b0;
        tick(); idle("rd1", 32'h40);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick(); idle("rd2", 32'h44);
        tick(); beat("rd40", 32'h40); check("rd3_addr", imem_addr, 32'h48);
        tick(); beat("rd44", 32'h44); check("rd4_addr", imem_addr, 32'h4C);

        // Halt: drain what is owed, then stay idle even after halt drops
        halt = 1'b1;
        tick(); beat("h48", 32'h48); check("h1_addr", imem_addr, 32'h4C);
        halt = 1'b0;
        tick(); idle("h2", 32'h4C);
        tick(); idle("h3", 32'h4C);

        // Redirect resumes from HALTED
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick(); idle("rs1", 32'h20);
        redirect_valid = 1'b0;
        tick(); idle("rs2", 32'h24);
        tick(); beat("rs20", 32'h20);
        check("rs_misalign", {31'h0, misalign_err}, 32'd0);

        // Misaligned redirect sets the sticky error and fetches aligned
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick(); idle("ma1", 32'h40);
        check("ma1_err", {31'h0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        tick(); idle("ma2", 32'h44);
        tick(); beat("ma40", 32'h40);
        tick(); beat("ma44", 32'h44);
        check("ma_sticky", {31'h0, misalign_err}, 32'd1);

        // Aligned redirect to the top of the address space: PC wraps
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(); idle("wr1", 32'hFFFF_FFFC);
        check("wr_sticky", {31'h0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        tick(); idle("wr2", 32'h0);
        tick(); beat("wrtop", 32'hFFFF_FFFC);
        tick(); beat("wr0", 32'h0);

        // Only reset clears the error
        reset = 1'b1;
        tick();
        idle("rst2", 32'h0);
        check("rst2_err", {31'h0, misalign_err}, 32'd0);
        reset = 1'b0;
        tick(); idle("rst2_c1", 32'h4);
        tick(); beat("rst2_s0", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
